// File: rtl/poly_uniform_rej_sampler_if.sv
// Block/poly bus of the uniform rejection sampler. The controller/squeeze side
// is the master; the sampler is the slave.
interface poly_uniform_rej_sampler_if #(
  parameter int N         = 256,
  parameter int BLK_BYTES = 168
);
  logic                   start;
  logic                   blk_req;
  logic                   blk_valid;
  logic                   blk_ready;
  logic [BLK_BYTES*8-1:0] blk_data;
  logic [N*32-1:0]        poly_out;
  logic [3:0]             blk_count;
  logic                   done;

  modport master (output start, blk_valid, blk_data,
                  input  blk_req, blk_ready, poly_out, blk_count, done);
  modport slave  (input  start, blk_valid, blk_data,
                  output blk_req, blk_ready, poly_out, blk_count, done);
endinterface

// File: rtl/poly_uniform_rej_sampler.sv
// Rejection sampler: turns SHAKE128 squeeze blocks into one uniform polynomial
// with 23-bit coefficients below Q, one triple evaluated per cycle.
module poly_uniform_rej_sampler #(
  parameter int unsigned Q         = 8380417,
  parameter int          N         = 256,
  parameter int          BLK_BYTES = 168
) (
  input  logic                        clock,
  input  logic                        reset,
  poly_uniform_rej_sampler_if.slave   bus
);
  localparam int TRIPLES = BLK_BYTES / 3;
  localparam int TIW     = $clog2(TRIPLES);
  localparam int CW      = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, WAIT_BLK, SAMPLE, DONE} state_t;

  state_t                    state_q, state_d;
  logic [TRIPLES-1:0][23:0]  blk_q;
  logic [N-1:0][31:0]        coef_q;
  logic [TIW-1:0]            ti_q;
  logic [CW-1:0]             cnt_q;
  logic [3:0]                blk_cnt_q;

  logic [22:0] t;
  logic        acc, xfer, last_triple, fills, restart;

  // Top bit of each triple's third byte is dropped here, never compared.
  assign t           = blk_q[ti_q][22:0];
  assign acc         = 32'(t) < Q;
  assign xfer        = (state_q == WAIT_BLK) && bus.blk_valid;
  assign last_triple = ti_q == TIW'(TRIPLES - 1);
  assign fills       = acc && (cnt_q == CW'(N - 1));
  assign restart     = bus.start && (state_q == IDLE || state_q == DONE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (bus.start)     state_d = WAIT_BLK;
      WAIT_BLK: if (bus.blk_valid) state_d = SAMPLE;
      SAMPLE:   if (fills)         state_d = DONE;
                else if (last_triple) state_d = WAIT_BLK;
      DONE:     if (bus.start)     state_d = WAIT_BLK;
      default:                     state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.blk_req   = state_q == WAIT_BLK;
    bus.blk_ready = state_q == WAIT_BLK;
    bus.done      = state_q == DONE;
  end

  assign bus.poly_out  = coef_q;
  assign bus.blk_count = blk_cnt_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      blk_q     <= '0;
      coef_q    <= '0;
      ti_q      <= '0;
      cnt_q     <= '0;
      blk_cnt_q <= '0;
    end else begin
      if (restart) begin
        cnt_q     <= '0;
        blk_cnt_q <= '0;
      end
      if (xfer) begin
        blk_q     <= bus.blk_data;
        ti_q      <= '0;
        blk_cnt_q <= (blk_cnt_q == 4'hF) ? blk_cnt_q : blk_cnt_q + 4'd1;
      end
      if (state_q == SAMPLE) begin
        if (acc) begin
          coef_q[cnt_q[CW-2:0]] <= 32'(t);
          cnt_q                 <= cnt_q + CW'(1);
        end
        if (!last_triple) ti_q <= ti_q + TIW'(1);
      end
    end
  end
endmodule

// File: tb/tb_poly_uniform_rej_sampler.sv
// Bench for the rejection sampler: boundary-triple table, directed multi-block
// sequences and randomized blocks checked against a byte-level reference model.
module tb_poly_uniform_rej_sampler;
  localparam int unsigned Q = 8380417;
  localparam int N  = 256;
  localparam int BB = 168;
  localparam int NT = BB / 3;

  typedef logic [BB*8-1:0] blk_t;
  typedef logic [N*32-1:0] poly_t;
  typedef struct {
    logic [7:0]  b0, b1, b2;
    bit          acc;
    int unsigned val;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  poly_uniform_rej_sampler_if #(.N(N), .BLK_BYTES(BB)) bus ();
  poly_uniform_rej_sampler #(.Q(Q), .N(N), .BLK_BYTES(BB)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );

  int   errs = 0;
  int   checks = 0;
  blk_t mem [16];

  function automatic blk_t get_block(int k);
    return (k < 16) ? mem[k] : '0;
  endfunction

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_poly(string name, poly_t exp);
    checks++;
    if (bus.poly_out !== exp) begin
      int first = 0;
      errs++;
      for (int i = N - 1; i >= 0; i--)
        if (bus.poly_out[32*i +: 32] !== exp[32*i +: 32]) first = i;
      $display("FAIL %s: coef[%0d] got %0d expected %0d", name, first,
               bus.poly_out[32*first +: 32], exp[32*first +: 32]);
    end
  endtask

  // Reference: walk the byte stream, accept values below Q until N are found.
  task automatic model(output poly_t p, output int nx);
    int   cnt;
    blk_t b;
    int unsigned v;
    cnt = 0; p = '0; nx = 0;
    while (cnt < N) begin
      b = get_block(nx);
      nx++;
      for (int j = 0; j < NT && cnt < N; j++) begin
        v = 32'(b[24*j +: 8]) + (32'(b[24*j+8 +: 8]) << 8)
          + ((32'(b[24*j+16 +: 8]) & 32'h7F) << 16);
        if (v < Q) begin
          p[32*cnt +: 32] = v;
          cnt++;
        end
      end
    end
  endtask

  task automatic set_triple(int k, int j, logic [7:0] b0, logic [7:0] b1, logic [7:0] b2);
    mem[k][24*j +: 24] = {b2, b1, b0};
  endtask

  task automatic fill_rand(int nblk);
    for (int k = 0; k < 16; k++) mem[k] = '0;
    for (int k = 0; k < nblk; k++)
      for (int j = 0; j < NT; j++)
        if ($urandom % 3 == 0)
          set_triple(k, j, 8'($urandom), ($urandom % 2) ? 8'hE0 : 8'($urandom),
                     8'h7F | 8'($urandom & 32'h80));
        else
          set_triple(k, j, 8'($urandom), 8'($urandom), 8'($urandom));
  endtask

  // Pulse start, then serve blocks from mem whenever requested.
  task automatic run(input int stall, input bit poke, input int abort_at,
                     output int nx, output int gap12, output int dlat);
    int  last, first, stall_left;
    bit  req, prev_req, ok;
    nx = 0; gap12 = -1; dlat = -1; last = 0; first = 0; stall_left = 0;
    prev_req = 0; ok = 0;
    @(negedge clock);
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    chk("start_to_req", bus.blk_req, 1);
    for (int cyc = 1; cyc < 20000; cyc++) begin
      req = bus.blk_req;
      bus.start = poke && !req && (cyc % 7 == 0);
      if (req && !prev_req) stall_left = stall;
      prev_req = req;
      if (req && stall_left > 0) begin
        bus.blk_valid = 1'b0;
        stall_left--;
      end else if (req) begin
        bus.blk_valid = 1'b1;
        bus.blk_data  = get_block(nx);
      end else begin
        bus.blk_valid = 1'($urandom);
        bus.blk_data  = ~get_block(nx);
      end
      @(posedge clock);
      if (req && bus.blk_valid) begin
        nx++;
        if (nx == 1) first = cyc;
        if (nx == 2) gap12 = cyc - first;
        last = cyc;
      end
      #1;
      if (bus.done) begin dlat = cyc - last; ok = 1; break; end
      if (abort_at != 0 && cyc == abort_at) begin ok = 1; break; end
      @(negedge clock);
    end
    bus.start = 1'b0;
    bus.blk_valid = 1'b0;
    if (!ok) chk("run_timeout", 0, 1);
  endtask

  vec_t  tbl [8];
  poly_t exp_p, ref_p;
  int    nx, gap, dlat, mnx, pos, nx0;

  initial begin
    bus.start = 1'b0; bus.blk_valid = 1'b0; bus.blk_data = '0;
    for (int k = 0; k < 16; k++) mem[k] = '0;
    repeat (3) @(negedge clock);
    chk_poly("rst_poly", '0);
    chk("rst_done", bus.done, 0);
    chk("rst_req", bus.blk_req, 0);
    chk("rst_ready", bus.blk_ready, 0);
    chk("rst_count", bus.blk_count, 0);
    reset = 1'b1;
    bus.blk_valid = 1'b1;
    repeat (3) @(negedge clock);
    chk("idle_valid_ignored", bus.blk_count, 0);
    chk("idle_no_ready", bus.blk_ready, 0);
    bus.blk_valid = 1'b0;

    // All-zero blocks: every triple accepted.
    run(0, 0, 0, nx, gap, dlat);
    chk("zero_xfers", nx, 5);
    chk("zero_count", bus.blk_count, 5);
    chk("zero_gap", gap, 57);
    chk("zero_done_lat", dlat, 32);
    chk_poly("zero_poly", '0);

    // One fully rejected block, then zeros.
    mem[0] = '1;
    run(0, 0, 0, nx, gap, dlat);
    chk("ff_xfers", nx, 6);
    chk("ff_count", bus.blk_count, 6);
    chk("ff_req_gap", gap, 57);
    chk_poly("ff_poly", '0);

    // Boundary triples at the head of block 1.
    tbl[0] = '{8'h00, 8'hE0, 8'h7F, 1'b1, 32'd8380416};
    tbl[1] = '{8'h01, 8'hE0, 8'h7F, 1'b0, 32'd0};
    tbl[2] = '{8'h01, 8'h00, 8'h80, 1'b1, 32'd1};
    tbl[3] = '{8'hFF, 8'hFF, 8'h7F, 1'b0, 32'd0};
    tbl[4] = '{8'hFF, 8'hDF, 8'h7F, 1'b1, 32'd8380415};
    tbl[5] = '{8'hFF, 8'hFF, 8'hFF, 1'b0, 32'd0};
    tbl[6] = '{8'h00, 8'hE0, 8'hFF, 1'b1, 32'd8380416};
    tbl[7] = '{8'h34, 8'h12, 8'h00, 1'b1, 32'd4660};
    for (int k = 0; k < 16; k++) mem[k] = '0;
    for (int i = 0; i < 8; i++) set_triple(0, i, tbl[i].b0, tbl[i].b1, tbl[i].b2);
    run(0, 0, 0, nx, gap, dlat);
    pos = 0;
    for (int i = 0; i < 8; i++)
      if (tbl[i].acc) begin
        chk($sformatf("tbl_coef%0d", pos), bus.poly_out[32*pos +: 32], tbl[i].val);
        pos++;
      end
    chk("tbl_next_zero", bus.poly_out[32*pos +: 32], 0);
    chk("tbl_count", bus.blk_count, 5);

    // Stalls and ignored start pulses must not change the result.
    fill_rand(8);
    model(ref_p, mnx);
    run(0, 0, 0, nx0, gap, dlat);
    chk_poly("plain_poly", ref_p);
    run(7, 1, 0, nx, gap, dlat);
    chk_poly("stall_poly", ref_p);
    chk("stall_xfers", nx, nx0);
    chk("stall_count", bus.blk_count, mnx);

    // Saturating block counter under long rejection.
    for (int k = 0; k < 16; k++) mem[k] = '1;
    run(0, 0, 0, nx, gap, dlat);
    chk("sat_xfers", nx, 21);
    chk("sat_count", bus.blk_count, 15);
    chk_poly("sat_poly", '0);

    for (int r = 0; r < 5; r++) begin
      fill_rand(8);
      model(exp_p, mnx);
      run(int'($urandom % 4), 1'($urandom), 0, nx, gap, dlat);
      chk_poly($sformatf("rand%0d_poly", r), exp_p);
      chk($sformatf("rand%0d_xfers", r), nx, mnx);
      chk($sformatf("rand%0d_count", r), bus.blk_count, (mnx > 15) ? 15 : mnx);
      chk($sformatf("rand%0d_done", r), bus.done, 1);
    end

    // Reset mid-sample, then a clean zero-block run.
    fill_rand(8);
    run(0, 0, 100, nx, gap, dlat);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk_poly("midrst_poly", '0);
    chk("midrst_done", bus.done, 0);
    chk("midrst_req", bus.blk_req, 0);
    chk("midrst_count", bus.blk_count, 0);
    @(negedge clock);
    reset = 1'b1;
    for (int k = 0; k < 16; k++) mem[k] = '0;
    run(0, 0, 0, nx, gap, dlat);
    chk("post_rst_xfers", nx, 5);
    chk("post_rst_count", bus.blk_count, 5);
    chk_poly("post_rst_poly", '0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/poly_uniform_rej_sampler.md
Name: poly_uniform_rej_sampler

Overview:
- Rejection sampler that turns the SHAKE128 squeeze output for one (rho, nonce) pair into one uniform polynomial of matrix A, with coefficients in [0, Q).
- Sits directly upstream of the matrix-expansion assembly. It consumes 168-byte squeezed blocks from the Keccak core and produces one 256-coefficient polynomial, packed in the same flat layout the mat buses use.
- The expansion controller runs it once per (row, column) entry.

Parameters:
- Q, 8380417, Dilithium modulus; accept threshold.
- N, 256, coefficients per polynomial.
- BLK_BYTES, 168, SHAKE128 rate in bytes (56 triples per block).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a new polynomial. Ignored unless in IDLE or DONE.
- blk_req  out  1  high while waiting for a squeezed block (state WAIT_BLK).
- blk_valid  in  1  squeezed block present on blk_data.
- blk_ready  out  1  equals blk_req; a transfer occurs when blk_valid && blk_ready.
- blk_data  in  1344  squeezed block; byte k at bits [8k+7:8k].
- poly_out  out  8192  256 coefficients × 32 bits; coefficient i at [32i+31:32i], zero-extended.
- blk_count  out  4  blocks consumed for the current polynomial (debug).
- done  out  1  high in DONE; held until the next accepted start or reset.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - poly_out, blk_count, triple index, coefficient count, block register all cleared to 0.
  - done=0, blk_req=0.
- States and transitions:
  - IDLE: on start, clear coefficient count and blk_count, go to WAIT_BLK.
  - WAIT_BLK: blk_req=blk_ready=1. On a transfer, latch blk_data, triple index ti=0, increment blk_count, go to SAMPLE. blk_data outside a transfer is don't-care.
  - SAMPLE: one triple per cycle.
    - t = {b[3ti+2] & 0x7F, b[3ti+1], b[3ti]}, 23 bits, little-endian.
    - If t < Q: write t to coefficient[cnt] and increment cnt.
    - If that write makes cnt=256: go to DONE; remaining triples in the block are discarded.
    - Else if ti=55: go to WAIT_BLK.
    - Else: increment ti.
  - DONE: done=1, poly_out stable. On start, clear cnt, blk_count and done, go to WAIT_BLK. Coefficients not yet rewritten keep their old values until overwritten.
- start in WAIT_BLK or SAMPLE: ignored; no restart.
- Latency:
  - start to blk_req=1: 1 cycle.
  - Block transfer to first triple evaluated: 1 cycle.
  - Each triple: exactly 1 cycle.
  - Final accepting write to done=1: 1 cycle.
  - With blk_valid held high and all triples accepted: 5 transfers, 256 sample cycles.
- Arithmetic:
  - The comparison is unsigned 23-bit.
  - Bit 7 of the third byte is always masked, never used.
  - t=8380416 (0x7FE000) is accepted; 0x7FE001..0x7FFFFF are rejected.
- Rejection gives no progress guarantee: the block keeps requesting blocks indefinitely. blk_count saturates at 15.
- Reset mid-operation: immediate return to IDLE, all state cleared, any partial poly lost. The in-flight upstream block is simply not acknowledged.
- The block never asserts blk_ready outside WAIT_BLK. A blk_valid while not ready has no effect.

Test Plan:
- All-zero blocks, blk_valid always high, start pulse:
  - Exactly 5 transfers occur.
  - 32 triples are consumed from block 5; all 256 coefficients = 0.
  - done rises 1 cycle after coefficient 255 is written; blk_count=5.
- Block of all 0xFF followed by all-zero blocks:
  - First block yields 0 coefficients and blk_req reasserts after 56 sample cycles.
  - Final blk_count=6 and poly_out is all zeros.
- Boundary triples at the head of block 1:
  - Bytes 00 E0 7F → 8380416 accepted as coefficient 0.
  - Bytes 01 E0 7F → rejected.
  - Bytes 01 00 80 → 1 accepted as coefficient 1 (masked bit 7).
  - Bytes FF FF 7F → rejected.
- Known vector: feed SHAKE128(rho=0x78695a4b…221100 || nonce 0x0000) blocks from the Keccak model → poly_out equals the reference-software A[0][0], coefficient by coefficient.
- Handshake stalls: blk_valid low for 7 cycles in WAIT_BLK, and start pulses during SAMPLE → no state change while stalled, result identical to the unstalled run.
- reset driven low for 1 cycle mid-SAMPLE (cnt≈100), then a new start with zero blocks:
  - Outputs are 0 immediately after reset.
  - The run completes normally with blk_count=5.
